sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO.
- Configurable data width, power-of-two depth and programmable almost-full/almost-empty thresholds.
- Sticky overflow/underflow error flags with a synchronous clear.
- General-purpose buffer between producer/consumer blocks in the same clock domain; drop-in successor to the fixed 8x8 FIFO.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when fifo_words >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when fifo_words <= AE_THRESH (0..DEPTH-1)
- CW (localparam), $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- full  out  1  fifo_words == DEPTH
- almost_full  out  1  fifo_words >= AF_THRESH
- rd_en  in  1  read request
- data_out  out  WIDTH  read data
- empty  out  1  fifo_words == 0
- almost_empty  out  1  fifo_words <= AE_THRESH
- fifo_words  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs and pointers: fifo_words=0, wr_ptr=rd_ptr=0, data_out=0, overflow=0, underflow=0.
  - Resulting status: empty=1, almost_empty=1, full=0, almost_full=0 (given AF_THRESH>=1).
  - Memory contents are not reset.
  - A reset mid-operation discards all stored words in one cycle.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered fifo_words.
  - They update in the cycle after the write/read that changes the count.
- Accepted operations: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read (default mode):
  - On rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments.
  - Latency is 1 cycle: data is valid on the edge after rd_en is sampled.
  - data_out holds its value when no read is accepted.
- Pointer width and wrap:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty are decided by fifo_words, not by pointer comparison.
- Count update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both or neither: unchanged.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - While full: only the read is accepted, the write is dropped and overflow sets.
  - While empty: only the write is accepted, the read is dropped and underflow sets; data_out does not change.
  - The written word is not bypassed to data_out.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until err_clr=1 or reset.
  - If set and clear conditions coincide, set wins.
  - Rejected requests never change pointers, count or memory.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr], combinational; it shows the head word whenever empty=0.
  - rd_en acknowledges/pops the head, and data_out shows the next word from the following cycle.
  - data_out is don't-care while empty.
  - Read latency 0; the data_out register and its reset are removed.
- Undefined: registered read as described in Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - function clog2-based count width helper.
  - Default threshold constants FIFO_AF_DEFAULT_MARGIN=2 and FIFO_AE_DEFAULT=2.
- One natural sub-module: fifo_ram.
  - WIDTH x DEPTH array with synchronous write and asynchronous read port.
  - The top level adds the output register in default mode.
- Pointer/count/flag logic stays in sync_fifo_param.

Test Plan (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2):
- Reset, then idle: empty=1, almost_empty=1, full=0, fifo_words=0, data_out=0x00, overflow=underflow=0.
- Write 0x10..0x17 (8 cycles):
  - almost_empty drops when fifo_words reaches 3.
  - almost_full rises at 6; full=1 at 8.
  - A 9th write of 0xFF sets overflow=1, fifo_words stays 8, and memory is unchanged.
- Read 8 words (default mode): data_out = 0x10..0x17, each one cycle after rd_en; empty=1 afterwards.
- Extra read while empty: underflow=1, data_out stays 0x17. Then err_clr=1 for one cycle: overflow=underflow=0.
- Wrap-around with fifo_words=4:
  - Assert wr_en and rd_en together for 20 cycles with incrementing data.
  - fifo_words stays 4 and the read order is exact across the pointer wrap.
- Reset asserted mid-stream with fifo_words=5: next cycle fifo_words=0, empty=1, and subsequent write/read returns the new data.
- With SYNC_FIFO_FWFT_EN: a single write of 0xA5 makes data_out=0xA5 while empty=0, before any rd_en; rd_en then gives empty=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Optional feature macro used by sync_fifo_param: SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  // Default distance of almost_full below DEPTH.
  localparam int unsigned FIFO_AF_DEFAULT_MARGIN = 2;
  // Default almost_empty threshold.
  localparam int unsigned FIFO_AE_DEFAULT = 2;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int unsigned fifo_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (data_out shows the
// head word combinationally); otherwise reads are registered with 1-cycle latency.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - FIFO_AF_DEFAULT_MARGIN,
  parameter int unsigned AE_THRESH = FIFO_AE_DEFAULT,
  localparam int unsigned CW       = fifo_count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    fifo_words,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int unsigned PW = CW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_words_q, fifo_words_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Status is decoded from the registered count only, never from pointers.
  assign full         = (fifo_words_q == CW'(DEPTH));
  assign empty        = (fifo_words_q == '0);
  assign almost_full  = (fifo_words_q >= CW'(AF_THRESH));
  assign almost_empty = (fifo_words_q <= CW'(AE_THRESH));
  assign fifo_words   = fifo_words_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_words_d = fifo_words_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);  // DEPTH is a power of two: natural wrap
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   fifo_words_d = fifo_words_q + CW'(1);
      2'b01:   fifo_words_d = fifo_words_q - CW'(1);
      default: fifo_words_d = fifo_words_q;
    endcase
    // Set has priority over a coincident clear.
    overflow_d  = (wr_en & full)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_words_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_words_q <= fifo_words_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible without a read request; undefined while empty.
  assign data_out = ram_rdata;
`else
  logic [WIDTH-1:0] data_q;

  // Registered read port: capture the head on an accepted read, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= ram_rdata;
    end
  end

  assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en, rd_en, err_clr;
  logic [WIDTH-1:0] data_in;
  logic             full, almost_full, empty, almost_empty, overflow, underflow;
  logic [WIDTH-1:0] data_out;
  logic [3:0]       fifo_words;

  int checks = 0;
  int errors = 0;

  // Reference model state (updated at rising edges) and scoreboard.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  bit               mon_en = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .fifo_words   (fifo_words),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: a queue of words plus two sticky bits.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        exp_q.delete();
        exp_q.push_back('0);
`endif
        mon_en = 1'b1;
      end else begin
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (wr_en && was_full)  m_ovf = 1'b1;
        if (rd_en && was_empty) m_unf = 1'b1;
        if (rd_en && !was_empty) begin
          logic [WIDTH-1:0] v;
          v = mq.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
          exp_q.push_back(v);
`endif
        end
        if (wr_en && !was_full) mq.push_back(data_in);
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the rising edge.
  initial begin
    logic [WIDTH-1:0] hold_v;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int n;
        n = mq.size();
        check("fifo_words",   32'(fifo_words),   32'(n));
        check("empty",        32'(empty),        32'(n == 0));
        check("full",         32'(full),         32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) check("data_out_head", 32'(data_out), 32'(mq[0]));
`else
        if (exp_q.size() > 0) hold_v = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(hold_v));
`endif
      end
    end
  end

  // One cycle of stimulus: inputs change on the falling edge.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                      input logic c);
    rst_n   = 1'b1;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    err_clr = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    @(negedge clk);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    check("reset_words", 32'(fifo_words), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("reset_data", 32'(data_out), 32'h00);
`endif

    // Fill, then one write too many.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("ovf_words", 32'(fifo_words), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);

    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
    check("drained_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, '0, 1'b0);
    check("unf_flag", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_data_hold", 32'(data_out), 32'h17);
`endif
    step(1'b0, 1'b0, '0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);

    // Steady state across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    check("wrap_words", 32'(fifo_words), 32'd4);

    // Reset mid-stream.
    step(1'b1, 1'b0, 8'h60, 1'b0);
    check("pre_rst_words", 32'(fifo_words), 32'd5);
    do_reset();
    check("rst_words", 32'(fifo_words), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b0, 8'h77, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_head", 32'(data_out), 32'h77);
`endif
    step(1'b0, 1'b1, '0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst_data", 32'(data_out), 32'h77);
`endif

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    check("fwft_a5", 32'(data_out), 32'hA5);
    check("fwft_not_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_pop_empty", 32'(empty), 32'd1);
`endif

    // Randomised traffic with shifting write/read bias and rare clears/resets.
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
               8'($urandom), 1'($urandom_range(0, 29) == 0));
        end
      end
    end

    step(1'b0, 1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
